// File: rtl/register_bank_8x16_if.sv
// Bus bundle between the datapath and the register bank: write port, PC control
// and the eight parallel register outputs that feed the bus-select mux.
interface register_bank_8x16_if #(
  parameter int unsigned WIDTH = 16
);
  logic [0:WIDTH-1] Din;
  logic             Wr_en;
  logic [0:2]       Wr_addr;
  logic             Pc_incr;
  logic             Hold;
  logic [0:WIDTH-1] R0, R1, R2, R3, R4, R5, R6, R7;
  logic             Pc_wrap;

  modport master (
    output Din, Wr_en, Wr_addr, Pc_incr, Hold,
    input  R0, R1, R2, R3, R4, R5, R6, R7, Pc_wrap
  );

  modport slave (
    input  Din, Wr_en, Wr_addr, Pc_incr, Hold,
    output R0, R1, R2, R3, R4, R5, R6, R7, Pc_wrap
  );
endinterface

// File: rtl/register_bank_8x16.sv
// Eight-entry general-purpose register bank; R7 is the program counter with its
// own increment path. All outputs come straight from flops.
module register_bank_8x16 #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [0:WIDTH-1] PC_RESET = '0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  register_bank_8x16_if.slave  bus
);

  logic [0:WIDTH-1] regs_q [8];
  logic [0:WIDTH-1] regs_d [8];
  logic             wrap_q;
  logic             wrap_d;
  logic [7:0]       wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      wr_sel[k] = (bus.Wr_addr == 3'(k));
    end
  end

  // A write to R7 is a jump and suppresses that cycle's PC increment.
  always_comb begin
    wrap_d = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      regs_d[k] = regs_q[k];
    end
    if (!bus.Hold) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (bus.Wr_en && wr_sel[k]) begin
          regs_d[k] = bus.Din;
        end
      end
      if (bus.Pc_incr && !(bus.Wr_en && wr_sel[7])) begin
        regs_d[7] = regs_q[7] + WIDTH'(1);
        wrap_d    = &regs_q[7];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int unsigned k = 0; k < 7; k++) begin
        regs_q[k] <= '0;
      end
      regs_q[7] <= PC_RESET;
      wrap_q    <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < 8; k++) begin
        regs_q[k] <= regs_d[k];
      end
      wrap_q <= wrap_d;
    end
  end

  assign bus.R0      = regs_q[0];
  assign bus.R1      = regs_q[1];
  assign bus.R2      = regs_q[2];
  assign bus.R3      = regs_q[3];
  assign bus.R4      = regs_q[4];
  assign bus.R5      = regs_q[5];
  assign bus.R6      = regs_q[6];
  assign bus.R7      = regs_q[7];
  assign bus.Pc_wrap = wrap_q;

endmodule

// File: tb/tb_register_bank_8x16.sv
// Scoreboard bench for register_bank_8x16: a driver pushes the model's predicted
// post-edge state, a monitor pops and compares it after every rising edge.
module tb_register_bank_8x16;

  logic Clock;
  logic Reset;

  register_bank_8x16_if #(.WIDTH(16)) ifc ();

  register_bank_8x16 #(.WIDTH(16), .PC_RESET(16'h0000)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (ifc)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0][15:0] r;
    logic             wrap;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned m_r[8];
  bit          m_wrap;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0][15:0] dut_regs();
    logic [7:0][15:0] v;
    v[0] = ifc.R0; v[1] = ifc.R1; v[2] = ifc.R2; v[3] = ifc.R3;
    v[4] = ifc.R4; v[5] = ifc.R5; v[6] = ifc.R6; v[7] = ifc.R7;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_r[k] = 0;
    m_wrap = 1'b0;
  endtask

  // Reference behaviour straight from the priority rules, on plain integers.
  task automatic model_step(input int unsigned din, input bit we, input int unsigned wa,
                            input bit inc, input bit hold);
    int unsigned pc;
    pc     = m_r[7];
    m_wrap = 1'b0;
    if (!hold) begin
      if (we) m_r[wa] = din;
      if (inc && !(we && wa == 7)) begin
        m_r[7] = (pc + 1) % 65536;
        m_wrap = (pc == 65535);
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int k = 0; k < 8; k++) e.r[k] = 16'(m_r[k]);
    e.wrap = m_wrap;
    exp_q.push_back(e);
  endtask

  // One bus cycle: drive between edges, confirm no write-through, predict the edge.
  task automatic cycle(input logic [15:0] din, input bit we, input int unsigned wa,
                       input bit inc, input bit hold);
    logic [7:0][15:0] now;
    @(negedge Clock);
    ifc.Din     = din;
    ifc.Wr_en   = we;
    ifc.Wr_addr = 3'(wa);
    ifc.Pc_incr = inc;
    ifc.Hold    = hold;
    #1;
    now = dut_regs();
    check("no_write_through", now[wa], 16'(m_r[wa]));
    model_step(din, we, wa, inc, hold);
    push_expected();
  endtask

  initial begin : monitor
    exp_t e;
    logic [7:0][15:0] act;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = dut_regs();
        for (int k = 0; k < 8; k++) check($sformatf("R%0d", k), act[k], e.r[k]);
        check("Pc_wrap", 16'(ifc.Pc_wrap), 16'(e.wrap));
      end
    end
  end

  initial begin : driver
    logic [7:0][15:0] act;
    ifc.Din = '0; ifc.Wr_en = 1'b0; ifc.Wr_addr = '0; ifc.Pc_incr = 1'b0; ifc.Hold = 1'b0;
    Reset = 1'b0;
    model_reset();

    // Asynchronous reset before any clock edge.
    #2 Reset = 1'b1;
    #1;
    act = dut_regs();
    for (int k = 0; k < 8; k++) check($sformatf("reset_R%0d", k), act[k], 16'h0000);
    check("reset_Pc_wrap", 16'(ifc.Pc_wrap), 16'h0000);
    repeat (2) @(negedge Clock);
    #2 Reset = 1'b0;

    // Write sweep.
    for (int k = 0; k < 8; k++) cycle(16'(16'h1111 * k), 1'b1, k, 1'b0, 1'b0);

    // PC increment across the wrap point.
    cycle(16'hFFFE, 1'b1, 7, 1'b0, 1'b0);
    repeat (3) cycle(16'h0000, 1'b0, 0, 1'b1, 1'b0);

    // A direct write of zero to R7 must not flag a wrap.
    cycle(16'hFFFF, 1'b1, 7, 1'b0, 1'b0);
    cycle(16'h0000, 1'b1, 7, 1'b0, 1'b0);

    // Simultaneous write and increment.
    cycle(16'h0010, 1'b1, 7, 1'b0, 1'b0);
    cycle(16'h0040, 1'b1, 7, 1'b1, 1'b0);
    cycle(16'hBEEF, 1'b1, 2, 1'b1, 1'b0);
    cycle(16'h5555, 1'b0, 3, 1'b0, 1'b0);

    // Hold freezes everything.
    cycle(16'h1234, 1'b1, 5, 1'b1, 1'b1);
    cycle(16'h0000, 1'b0, 0, 1'b0, 1'b0);

    // Reset between edges while a write is pending.
    @(posedge Clock);
    #3;
    ifc.Din = 16'hABCD; ifc.Wr_en = 1'b1; ifc.Wr_addr = 3'd5; ifc.Pc_incr = 1'b1;
    #2 Reset = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    act = dut_regs();
    for (int k = 0; k < 8; k++) check($sformatf("midreset_R%0d", k), act[k], 16'h0000);
    check("midreset_Pc_wrap", 16'(ifc.Pc_wrap), 16'h0000);
    @(posedge Clock);
    #1;
    act = dut_regs();
    check("reset_ignores_edge_R5", act[5], 16'h0000);
    check("reset_ignores_edge_R7", act[7], 16'h0000);
    @(negedge Clock);
    ifc.Wr_en = 1'b0; ifc.Pc_incr = 1'b0;
    #2 Reset = 1'b0;
    repeat (2) cycle(16'h0000, 1'b0, 0, 1'b0, 1'b0);

    // Randomized traffic, with occasional PC preloads near the wrap point.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] din;
      int unsigned wa;
      bit we, inc, hold;
      din  = 16'($urandom);
      wa   = $urandom_range(0, 7);
      we   = ($urandom_range(0, 1) == 1);
      inc  = ($urandom_range(0, 1) == 1);
      hold = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 15) == 0) begin
        din = 16'hFFFD; we = 1'b1; wa = 7; hold = 1'b0;
      end
      cycle(din, we, wa, inc, hold);
    end

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge Clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_bank_8x16.md
Name: register_bank_8x16

Overview:
- Eight-entry, 16-bit general-purpose register bank for the DE0 processor datapath.
- Sits directly upstream of the 16-bit 8:1 bus-select mux: all eight register contents are driven out in parallel, and the mux picks one onto the datapath bus.
- R7 doubles as the program counter and has a dedicated increment path.
- A single write port loads from the datapath bus (Din).

Parameters:
- WIDTH, 16, register/data width in bits; all data ports are [0:WIDTH-1], bit 0 = MSB.
- PC_RESET, 16'h0000, reset value of R7 (program counter).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Din  in  WIDTH  write data from the datapath bus.
- Wr_en  in  1  write enable; 1 = load Din into the register selected by Wr_addr.
- Wr_addr  in  [0:2]  write target index 0..7; bit 0 = MSB.
- Pc_incr  in  1  1 = increment R7 by 1.
- Hold  in  1  1 = freeze all registers; Wr_en and Pc_incr are ignored.
- R0..R7  out  WIDTH each  current register contents; these feed mux inputs i1..i8 in order.
- Pc_wrap  out  1  one-cycle pulse when an R7 increment wraps from all-ones to zero.

Behaviour:
- Reset (async, active-high):
  - Asserting Reset immediately forces R0..R6 = 0, R7 = PC_RESET, Pc_wrap = 0, independent of Clock.
  - While Reset is high, all clock edges are ignored.
  - The first update occurs on the first rising edge after Reset deasserts.
  - Reset mid-write or mid-increment discards the pending operation.
- Storage:
  - All outputs are direct register outputs; no combinational path from any input to R0..R7.
  - Write latency is 1 cycle: data written on edge N is visible on Rk immediately after edge N.
  - No write-through: in the cycle a write is issued, Rk still shows the old value.
- Per rising edge, priority order:
  1. Hold = 1: all registers keep their value; Pc_wrap <= 0.
  2. Wr_en = 1: R[Wr_addr] <= Din. All other registers are unchanged, except R7 (see next rule).
  3. Pc_incr = 1 and not (Wr_en = 1 and Wr_addr = 7): R7 <= (R7 + 1) mod 2^WIDTH.
- Simultaneous events:
  - Wr_en = 1 to R0..R6 with Pc_incr = 1: both take effect on the same edge.
  - Wr_en = 1 to R7 with Pc_incr = 1: the write wins; R7 <= Din and no increment (jump overrides PC advance).
  - Wr_en = 0 and Pc_incr = 0: every register holds.
- Arithmetic:
  - Increment is unsigned WIDTH-bit and wraps silently.
  - Pc_wrap <= 1 exactly on the edge where R7 goes from all-ones to 0 through the increment path; otherwise Pc_wrap <= 0.
  - A direct write of 0 to R7 never sets Pc_wrap.
- Unknown inputs: the Wr_addr decode is a full one-hot 3-to-8 decode. An X on Wr_en or Wr_addr is a bench error, not a design requirement.

Test Plan:
- Reset check: assert Reset asynchronously, no clock edge -> R0..R6 = 16'h0000, R7 = 16'h0000 (default PC_RESET), Pc_wrap = 0.
- Write sweep: for k = 0..7, Wr_en = 1, Wr_addr = k, Din = 16'h1111*k.
  - Each Rk updates one cycle after its edge; all other registers are unchanged.
  - Final state: R3 = 16'h3333, R7 = 16'h7777.
- PC increment and wrap: write R7 = 16'hFFFE, then Pc_incr = 1 for 3 cycles.
  - R7 sequence: FFFF, 0000, 0001.
  - Pc_wrap is high only in the cycle after the FFFF->0000 edge.
- Simultaneous events:
  - Pc_incr = 1 with Wr_en = 1, Wr_addr = 7, Din = 16'h0040, R7 = 16'h0010 -> R7 = 16'h0040.
  - Pc_incr = 1 with Wr_addr = 2, Din = 16'hBEEF -> R2 = 16'hBEEF and R7 = 16'h0041 on the same edge.
- Hold and reset mid-operation:
  - Hold = 1 with Wr_en = 1 to R5 and Pc_incr = 1 -> no register changes.
  - Asserting Reset between edges while Wr_en is active -> all registers clear immediately; the write is not applied after Reset drops.
